// File: rtl/bram_pkg.sv
// bram_pkg: write-mode encodings, parameter limits and clog2 shared by the BRAM files
package bram_pkg;
  typedef enum int {
    WRITE_FIRST = 0,
    READ_FIRST  = 1,
    NO_CHANGE   = 2
  } wmode_e;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16384;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/bram_sp_gen_if.sv
// bram_sp_gen_if: single-port RAM access bus with requester and memory views
interface bram_sp_gen_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 9
);
  logic             EN;
  logic             WE;
  logic [AW-1:0]    ADDR;
  logic [WIDTH-1:0] DI;
  logic [WIDTH-1:0] DO;
  logic             VALID;
  modport master (output EN, WE, ADDR, DI, input DO, VALID);
  modport slave  (input EN, WE, ADDR, DI, output DO, VALID);
endinterface

// File: rtl/bram_out_reg.sv
// bram_out_reg: data register with load enable plus a valid bit, both reset synchronously
module bram_out_reg #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SRVAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ld_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             v_o
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             v_q;
  // data only moves on a load; otherwise the last result is held
  always_comb q_d = ld_i ? d_i : q_q;
  // reset wins over any load and drops valid; valid otherwise follows its input every edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= SRVAL;
      v_q <= 1'b0;
    end else begin
      q_q <= q_d;
      v_q <= v_i;
    end
  end
  assign q_o = q_q;
  assign v_o = v_q;
endmodule

// File: rtl/bram_sp_gen.sv
// bram_sp_gen: generic single-port block RAM with selectable write mode and optional output register
module bram_sp_gen
  import bram_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 512,
  parameter int               WRITE_MODE = WRITE_FIRST,
  parameter int               DO_REG     = 0,
  parameter logic [WIDTH-1:0] SRVAL      = '0,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
  input logic          CLK,
  input logic          RST,
  bram_sp_gen_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam bit WF = WRITE_MODE == WRITE_FIRST;
  localparam bit NC = WRITE_MODE == NO_CHANGE;
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX ||
      WRITE_MODE < 0 || WRITE_MODE > 2 || DO_REG < 0 || DO_REG > 1) begin : g_bad_param
    $error("bram_sp_gen: illegal parameters WIDTH=%0d DEPTH=%0d WRITE_MODE=%0d DO_REG=%0d",
           WIDTH, DEPTH, WRITE_MODE, DO_REG);
  end
  logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT_VAL};
  logic             in_rng, lat_ld, lat_v;
  logic [WIDTH-1:0] rd_data, lat_d, lat_q;
  // out-of-range addresses read as zero; a NO_CHANGE write neither loads nor marks valid
  always_comb begin
    in_rng  = 32'(bus.ADDR) < DEPTH;
    rd_data = in_rng ? mem[bus.ADDR] : '0;
    lat_d   = (bus.WE && WF) ? bus.DI : rd_data;
    lat_ld  = bus.EN && !(bus.WE && NC);
  end
  // memory ignores reset so a write issued during reset still lands
  always_ff @(posedge CLK) begin
    if (bus.EN && bus.WE && in_rng) mem[bus.ADDR] <= bus.DI;
  end
  bram_out_reg #(.WIDTH(WIDTH), .SRVAL(SRVAL)) u_lat (
    .CLK  (CLK),
    .RST  (RST),
    .ld_i (lat_ld),
    .v_i  (lat_ld),
    .d_i  (lat_d),
    .q_o  (lat_q),
    .v_o  (lat_v)
  );
  if (DO_REG == 1) begin : g_do_reg
    bram_out_reg #(.WIDTH(WIDTH), .SRVAL(SRVAL)) u_out (
      .CLK  (CLK),
      .RST  (RST),
      .ld_i (1'b1),
      .v_i  (lat_v),
      .d_i  (lat_q),
      .q_o  (bus.DO),
      .v_o  (bus.VALID)
    );
  end else begin : g_no_reg
    assign bus.DO    = lat_q;
    assign bus.VALID = lat_v;
  end
endmodule

// File: tb/tb_bram_sp_gen.sv
// tb_bram_sp_gen: directed scoreboard bench over five differently configured RAM instances
module tb_bram_sp_gen;
  import bram_pkg::*;
  typedef struct {
    int         id;
    int         due;
    logic [7:0] d;
    logic       v;
    string      tag;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst    [5];
  logic       en     [5];
  logic       we     [5];
  logic [8:0] addr   [5];
  logic [7:0] di     [5];
  logic [7:0] obs_do [5];
  logic       obs_v  [5];
  exp_t       sb [$];
  int         cyc = 0;
  int         n_run = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  bram_sp_gen_if #(.WIDTH(8), .AW(9)) if0 ();
  bram_sp_gen_if #(.WIDTH(8), .AW(9)) if1 ();
  bram_sp_gen_if #(.WIDTH(8), .AW(9)) if2 ();
  bram_sp_gen_if #(.WIDTH(8), .AW(9)) if3 ();
  bram_sp_gen_if #(.WIDTH(8), .AW(9)) if4 ();
  bram_sp_gen #(.WIDTH(8), .DEPTH(512), .WRITE_MODE(WRITE_FIRST), .DO_REG(0))
    u0 (.CLK(clk), .RST(rst[0]), .bus(if0));
  bram_sp_gen #(.WIDTH(8), .DEPTH(512), .WRITE_MODE(READ_FIRST), .DO_REG(0), .INIT_VAL(8'h3C))
    u1 (.CLK(clk), .RST(rst[1]), .bus(if1));
  bram_sp_gen #(.WIDTH(8), .DEPTH(512), .WRITE_MODE(NO_CHANGE), .DO_REG(0))
    u2 (.CLK(clk), .RST(rst[2]), .bus(if2));
  bram_sp_gen #(.WIDTH(8), .DEPTH(512), .WRITE_MODE(WRITE_FIRST), .DO_REG(1), .SRVAL(8'hFF))
    u3 (.CLK(clk), .RST(rst[3]), .bus(if3));
  bram_sp_gen #(.WIDTH(8), .DEPTH(300), .WRITE_MODE(WRITE_FIRST), .DO_REG(0))
    u4 (.CLK(clk), .RST(rst[4]), .bus(if4));
  assign if0.EN = en[0]; assign if0.WE = we[0]; assign if0.ADDR = addr[0]; assign if0.DI = di[0];
  assign if1.EN = en[1]; assign if1.WE = we[1]; assign if1.ADDR = addr[1]; assign if1.DI = di[1];
  assign if2.EN = en[2]; assign if2.WE = we[2]; assign if2.ADDR = addr[2]; assign if2.DI = di[2];
  assign if3.EN = en[3]; assign if3.WE = we[3]; assign if3.ADDR = addr[3]; assign if3.DI = di[3];
  assign if4.EN = en[4]; assign if4.WE = we[4]; assign if4.ADDR = addr[4]; assign if4.DI = di[4];
  assign obs_do[0] = if0.DO; assign obs_v[0] = if0.VALID;
  assign obs_do[1] = if1.DO; assign obs_v[1] = if1.VALID;
  assign obs_do[2] = if2.DO; assign obs_v[2] = if2.VALID;
  assign obs_do[3] = if3.DO; assign obs_v[3] = if3.VALID;
  assign obs_do[4] = if4.DO; assign obs_v[4] = if4.VALID;

  task automatic idle();
    for (int i = 0; i < 5; i++) begin
      en[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; di[i] = '0;
    end
  endtask

  task automatic acc(input int id, input logic w, input logic [8:0] a, input logic [7:0] d);
    en[id] = 1'b1; we[id] = w; addr[id] = a; di[id] = d;
  endtask

  task automatic exp_out(input int id, input int lat, input logic [7:0] d, input logic v, input string tag);
    exp_t e;
    e.id = id; e.due = cyc + lat; e.d = d; e.v = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic go();
    int   k;
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].due == cyc) begin
        e = sb[k];
        n_run++;
        assert (obs_do[e.id] === e.d && obs_v[e.id] === e.v) else begin
          n_fail++;
          $error("FAIL %s: got DO=%h VALID=%b, want DO=%h VALID=%b",
                 e.tag, obs_do[e.id], obs_v[e.id], e.d, e.v);
        end
        sb.delete(k);
      end else k++;
    end
    idle();
  endtask

  initial begin
    int pend;
    idle();
    for (int i = 0; i < 5; i++) rst[i] = 1'b1;
    for (int i = 0; i < 5; i++) exp_out(i, 1, (i == 3) ? 8'hFF : 8'h00, 1'b0, "reset_state");
    go();
    for (int i = 0; i < 5; i++) rst[i] = 1'b0;
    for (int i = 0; i < 5; i++) exp_out(i, 1, (i == 3) ? 8'hFF : 8'h00, 1'b0, "post_reset_idle");
    go();
    acc(0, 1'b1, 9'h010, 8'hA5); exp_out(0, 1, 8'hA5, 1'b1, "wf_write"); go();
    acc(0, 1'b0, 9'h010, 8'h00); exp_out(0, 1, 8'hA5, 1'b1, "wf_read"); go();
    exp_out(0, 1, 8'hA5, 1'b0, "en0_hold"); go();
    acc(0, 1'b1, 9'h030, 8'h11); exp_out(0, 1, 8'h11, 1'b1, "wf_first"); go();
    acc(0, 1'b1, 9'h030, 8'h22); exp_out(0, 1, 8'h22, 1'b1, "wf_second"); go();
    acc(0, 1'b0, 9'h030, 8'h00); exp_out(0, 1, 8'h22, 1'b1, "last_write_wins"); go();
    rst[0] = 1'b1;
    acc(0, 1'b1, 9'h020, 8'h42); exp_out(0, 1, 8'h00, 1'b0, "rst_write_do"); go();
    rst[0] = 1'b0;
    acc(0, 1'b0, 9'h020, 8'h00); exp_out(0, 1, 8'h42, 1'b1, "rst_write_mem"); go();
    acc(1, 1'b1, 9'h005, 8'h77); exp_out(1, 1, 8'h3C, 1'b1, "rf_old_data"); go();
    acc(1, 1'b0, 9'h005, 8'h00); exp_out(1, 1, 8'h77, 1'b1, "rf_read_new"); go();
    acc(1, 1'b0, 9'h100, 8'h00); exp_out(1, 1, 8'h3C, 1'b1, "init_val"); go();
    rst[1] = 1'b1; exp_out(1, 1, 8'h00, 1'b0, "rf_reset"); go();
    rst[1] = 1'b0;
    acc(1, 1'b0, 9'h005, 8'h00); exp_out(1, 1, 8'h77, 1'b1, "mem_survives_rst"); go();
    acc(2, 1'b1, 9'h001, 8'h11); exp_out(2, 1, 8'h00, 1'b0, "nc_write_hold"); go();
    acc(2, 1'b0, 9'h001, 8'h00); exp_out(2, 1, 8'h11, 1'b1, "nc_read"); go();
    acc(2, 1'b1, 9'h002, 8'h99); exp_out(2, 1, 8'h11, 1'b0, "nc_write_no_change"); go();
    acc(2, 1'b0, 9'h002, 8'h00); exp_out(2, 1, 8'h99, 1'b1, "nc_read_new"); go();
    acc(3, 1'b1, 9'h000, 8'h10); exp_out(3, 2, 8'h10, 1'b1, "reg_wr0"); go();
    acc(3, 1'b1, 9'h001, 8'h20); exp_out(3, 2, 8'h20, 1'b1, "reg_wr1"); go();
    acc(3, 1'b1, 9'h002, 8'h30); exp_out(3, 2, 8'h30, 1'b1, "reg_wr2"); go();
    acc(3, 1'b0, 9'h000, 8'h00); exp_out(3, 2, 8'h10, 1'b1, "reg_rd0"); go();
    acc(3, 1'b0, 9'h001, 8'h00); exp_out(3, 2, 8'h20, 1'b1, "reg_rd1"); go();
    acc(3, 1'b0, 9'h002, 8'h00); exp_out(3, 2, 8'h30, 1'b1, "reg_rd2"); go();
    exp_out(3, 2, 8'h30, 1'b0, "reg_drain"); go();
    go();
    acc(3, 1'b0, 9'h001, 8'h00); go();
    rst[3] = 1'b1; exp_out(3, 1, 8'hFF, 1'b0, "rst_mid_pipe"); go();
    rst[3] = 1'b0; exp_out(3, 1, 8'hFF, 1'b0, "no_stale_result"); go();
    acc(3, 1'b0, 9'h002, 8'h00); exp_out(3, 2, 8'h30, 1'b1, "reg_after_rst"); go();
    acc(4, 1'b1, 9'd310, 8'h55); go();
    acc(4, 1'b0, 9'd310, 8'h00); exp_out(4, 1, 8'h00, 1'b1, "oor_read"); go();
    acc(4, 1'b0, 9'd54, 8'h00); exp_out(4, 1, 8'h00, 1'b1, "oor_no_alias"); go();
    acc(4, 1'b1, 9'd299, 8'h66); exp_out(4, 1, 8'h66, 1'b1, "top_word_write"); go();
    acc(4, 1'b0, 9'd299, 8'h00); exp_out(4, 1, 8'h66, 1'b1, "top_word_read"); go();
    go();
    go();
    pend = sb.size();
    n_run++;
    assert (pend == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: got %0d pending, want 0", pend);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
